// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one 256x16 block RAM between a read-only fetch port and a byte-masked
// load/store port, splitting each 32-bit access into two 16-bit RAM cycles (low half first).
module ram_port_arbiter #(
    parameter int WADDR_W = 7,
    parameter int RAM_DW  = 16
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    if_req_i,
    input  logic [WADDR_W-1:0]      if_addr_i,
    output logic                    if_gnt_o,
    output logic                    if_rvalid_o,
    output logic [2*RAM_DW-1:0]     if_rdata_o,
    input  logic                    ls_req_i,
    input  logic                    ls_we_i,
    input  logic [WADDR_W-1:0]      ls_addr_i,
    input  logic [2*RAM_DW-1:0]     ls_wdata_i,
    input  logic [2*RAM_DW/8-1:0]   ls_be_i,
    output logic                    ls_gnt_o,
    output logic                    ls_done_o,
    output logic [2*RAM_DW-1:0]     ls_rdata_o,
    output logic [WADDR_W:0]        ram_raddr_o,
    output logic                    ram_re_o,
    input  logic [RAM_DW-1:0]       ram_rdata_i,
    output logic [WADDR_W:0]        ram_waddr_o,
    output logic [RAM_DW-1:0]       ram_wdata_o,
    output logic [RAM_DW-1:0]       ram_mask_o,
    output logic                    ram_we_o
);
    localparam int HB = RAM_DW / 8;
    localparam int DW = 2 * RAM_DW;

    typedef enum logic [2:0] {IDLE, RD0, RD1, RD2, WR0, WR1} state_t;

    state_t              state_q, state_d;
    logic                ptr_q, ptr_d;
    logic                src_q, src_d;
    logic [WADDR_W-1:0]  addr_q, addr_d;
    logic [DW-1:0]       wdata_q, wdata_d;
    logic [2*HB-1:0]     be_q, be_d;
    logic [RAM_DW-1:0]   lo_q, lo_d;
    logic                if_rvalid_q, if_rvalid_d;
    logic                ls_done_q, ls_done_d;
    logic [DW-1:0]       if_rdata_q, if_rdata_d;
    logic [DW-1:0]       ls_rdata_q, ls_rdata_d;
    logic                idle, in_wr, rd_done;
    logic [HB-1:0]       half_be;

    // ptr_q=1 means the load/store port was not granted last and wins a tie
    always_comb begin
        idle     = state_q == IDLE;
        if_gnt_o = !reset_i && idle && if_req_i && !(ls_req_i && ptr_q);
        ls_gnt_o = !reset_i && idle && ls_req_i && !if_gnt_o;
        state_d  = state_q;
        ptr_d    = ptr_q;
        src_d    = src_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        lo_d     = lo_q;
        rd_done  = 1'b0;
        ls_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (if_gnt_o) begin
                    state_d = RD0;
                    ptr_d   = 1'b1;
                    src_d   = 1'b0;
                    addr_d  = if_addr_i;
                end else if (ls_gnt_o) begin
                    state_d = ls_we_i ? WR0 : RD0;
                    ptr_d   = 1'b0;
                    src_d   = 1'b1;
                    addr_d  = ls_addr_i;
                    wdata_d = ls_wdata_i;
                    be_d    = ls_be_i;
                end
            end
            RD0: state_d = RD1;
            RD1: begin
                state_d = RD2;
                lo_d    = ram_rdata_i;
            end
            RD2: begin
                state_d = IDLE;
                rd_done = 1'b1;
            end
            WR0: state_d = WR1;
            WR1: begin
                state_d   = IDLE;
                ls_done_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if_rvalid_d = rd_done && !src_q;
        ls_done_d   = ls_done_d || (rd_done && src_q);
        if_rdata_d  = (rd_done && !src_q) ? {ram_rdata_i, lo_q} : if_rdata_q;
        ls_rdata_d  = (rd_done && src_q) ? {ram_rdata_i, lo_q} : ls_rdata_q;
    end

    // RAM pins are decoded from the state; enables are killed while reset is high
    always_comb begin
        in_wr       = state_q == WR0 || state_q == WR1;
        half_be     = state_q == WR1 ? be_q[2*HB-1:HB] : be_q[HB-1:0];
        ram_re_o    = !reset_i && (state_q == RD0 || state_q == RD1);
        ram_raddr_o = state_q == RD0 ? {addr_q, 1'b0} : state_q == RD1 ? {addr_q, 1'b1} : '0;
        ram_we_o    = !reset_i && in_wr && |half_be;
        ram_waddr_o = in_wr ? {addr_q, state_q == WR1} : '0;
        ram_wdata_o = state_q == WR0 ? wdata_q[RAM_DW-1:0] :
                      state_q == WR1 ? wdata_q[DW-1:RAM_DW] : '0;
        ram_mask_o  = '1;
        if (in_wr)
            for (int j = 0; j < HB; j++)
                ram_mask_o[j*8 +: 8] = {8{!half_be[j]}};
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            ptr_q       <= 1'b0;
            src_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            lo_q        <= '0;
            if_rvalid_q <= 1'b0;
            ls_done_q   <= 1'b0;
            if_rdata_q  <= '0;
            ls_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            src_q       <= src_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            lo_q        <= lo_d;
            if_rvalid_q <= if_rvalid_d;
            ls_done_q   <= ls_done_d;
            if_rdata_q  <= if_rdata_d;
            ls_rdata_q  <= ls_rdata_d;
        end
    end

    assign if_rvalid_o = if_rvalid_q;
    assign if_rdata_o  = if_rdata_q;
    assign ls_done_o   = ls_done_q;
    assign ls_rdata_o  = ls_rdata_q;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed scenarios against a bench-owned 256x16 RAM with registered read.
module tb_ram_port_arbiter;
    logic        clk = 0, reset = 1;
    logic        if_req = 0, if_gnt, if_rvalid;
    logic [6:0]  if_addr = 0;
    logic [31:0] if_rdata;
    logic        ls_req = 0, ls_we = 0, ls_gnt, ls_done;
    logic [6:0]  ls_addr = 0;
    logic [31:0] ls_wdata = 0, ls_rdata;
    logic [3:0]  ls_be = 0;
    logic [7:0]  ram_raddr, ram_waddr;
    logic        ram_re, ram_we;
    logic [15:0] ram_rdata = 0, ram_wdata, ram_mask;
    logic [15:0] mem [256];
    int          tests = 0, fails = 0;

    ram_port_arbiter dut (
        .clk_i(clk), .reset_i(reset),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
        .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
        .ls_req_i(ls_req), .ls_we_i(ls_we), .ls_addr_i(ls_addr), .ls_wdata_i(ls_wdata),
        .ls_be_i(ls_be), .ls_gnt_o(ls_gnt), .ls_done_o(ls_done), .ls_rdata_o(ls_rdata),
        .ram_raddr_o(ram_raddr), .ram_re_o(ram_re), .ram_rdata_i(ram_rdata),
        .ram_waddr_o(ram_waddr), .ram_wdata_o(ram_wdata), .ram_mask_o(ram_mask),
        .ram_we_o(ram_we)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we)
            for (int b = 0; b < 16; b++)
                if (!ram_mask[b]) mem[ram_waddr][b] <= ram_wdata[b];
        if (ram_re) ram_rdata <= mem[ram_raddr];
    end

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1;
        tick; tick;
        tests++; if ({if_gnt, ls_gnt, if_rvalid, ls_done} !== 4'b0) begin fails++; $display("FAIL reset_pulses got %b exp 0000", {if_gnt, ls_gnt, if_rvalid, ls_done}); end
        tests++; if ({if_rdata, ls_rdata} !== 64'h0) begin fails++; $display("FAIL reset_rdata got %h exp 0", {if_rdata, ls_rdata}); end
        tests++; if ({ram_re, ram_we, ram_raddr, ram_waddr, ram_wdata, ram_mask} !== {2'b00, 32'h0, 16'hFFFF}) begin fails++; $display("FAIL reset_pins re=%b we=%b ra=%h wa=%h wd=%h mask=%h exp idle", ram_re, ram_we, ram_raddr, ram_waddr, ram_wdata, ram_mask); end
        reset = 0;
        tick;
    endtask

    task automatic test_write;
        ls_req = 1; ls_we = 1; ls_addr = 7'h05; ls_wdata = 32'hDEADBEEF; ls_be = 4'hF;
        #1;
        tests++; if ({ls_gnt, if_gnt} !== 2'b10) begin fails++; $display("FAIL wr_gnt got %b exp 10", {ls_gnt, if_gnt}); end
        tick; ls_req = 0;
        tests++; if ({ram_we, ram_waddr, ram_wdata, ram_mask} !== {1'b1, 8'h0A, 16'hBEEF, 16'h0000}) begin fails++; $display("FAIL wr0_pins got %b %h %h %h exp 1 0a beef 0000", ram_we, ram_waddr, ram_wdata, ram_mask); end
        tick;
        tests++; if ({ram_we, ram_waddr, ram_wdata, ram_mask} !== {1'b1, 8'h0B, 16'hDEAD, 16'h0000}) begin fails++; $display("FAIL wr1_pins got %b %h %h %h exp 1 0b dead 0000", ram_we, ram_waddr, ram_wdata, ram_mask); end
        tick;
        tests++; if (ls_done !== 1'b1) begin fails++; $display("FAIL wr_done got %b exp 1", ls_done); end
        tests++; if ({mem[8'h0A], mem[8'h0B]} !== 32'hBEEFDEAD) begin fails++; $display("FAIL wr_mem got %h %h exp beef dead", mem[8'h0A], mem[8'h0B]); end
        tick;
        tests++; if (ls_done !== 1'b0) begin fails++; $display("FAIL wr_done_pulse got %b exp 0", ls_done); end
    endtask

    task automatic test_fetch;
        if_req = 1; if_addr = 7'h05;
        #1;
        tests++; if (if_gnt !== 1'b1) begin fails++; $display("FAIL if_gnt got %b exp 1", if_gnt); end
        tick; if_req = 0;
        tests++; if ({ram_re, ram_raddr} !== {1'b1, 8'h0A}) begin fails++; $display("FAIL rd0_pins got %b %h exp 1 0a", ram_re, ram_raddr); end
        tick;
        tests++; if ({ram_re, ram_raddr} !== {1'b1, 8'h0B}) begin fails++; $display("FAIL rd1_pins got %b %h exp 1 0b", ram_re, ram_raddr); end
        tick;
        tests++; if ({ram_re, if_rvalid} !== 2'b00) begin fails++; $display("FAIL rd2_pins got %b exp 00", {ram_re, if_rvalid}); end
        tick;
        tests++; if ({if_rvalid, if_rdata} !== {1'b1, 32'hDEADBEEF}) begin fails++; $display("FAIL if_rdata got %b %h exp 1 deadbeef", if_rvalid, if_rdata); end
        tick;
        tests++; if ({if_rvalid, if_rdata} !== {1'b0, 32'hDEADBEEF}) begin fails++; $display("FAIL if_hold got %b %h exp 0 deadbeef", if_rvalid, if_rdata); end
    endtask

    task automatic test_byte_write;
        ls_req = 1; ls_we = 1; ls_addr = 7'h05; ls_wdata = 32'h00AA0000; ls_be = 4'b0100;
        #1;
        tick; ls_req = 0;
        tests++; if (ram_we !== 1'b0) begin fails++; $display("FAIL bw_wr0_we got %b exp 0", ram_we); end
        tick;
        tests++; if ({ram_we, ram_mask} !== {1'b1, 16'hFF00}) begin fails++; $display("FAIL bw_wr1 got %b %h exp 1 ff00", ram_we, ram_mask); end
        tick;
        tests++; if (ls_done !== 1'b1) begin fails++; $display("FAIL bw_done got %b exp 1", ls_done); end
        tick;
        ls_req = 1; ls_we = 0;
        #1;
        tick; ls_req = 0;
        tick; tick; tick;
        tests++; if ({ls_done, ls_rdata} !== {1'b1, 32'hDEAABEEF}) begin fails++; $display("FAIL bw_readback got %b %h exp 1 deaabeef", ls_done, ls_rdata); end
        tests++; if (if_rvalid !== 1'b0) begin fails++; $display("FAIL bw_no_rvalid got %b exp 0", if_rvalid); end
        tick;
    endtask

    task automatic test_arbitration;
        reset = 1; tick; reset = 0;
        if_req = 1; if_addr = 7'h05; ls_req = 1; ls_we = 0; ls_addr = 7'h05;
        #1;
        tests++; if ({if_gnt, ls_gnt} !== 2'b10) begin fails++; $display("FAIL tie1 got %b exp 10", {if_gnt, ls_gnt}); end
        tick; if_req = 0;
        tests++; if (ls_gnt !== 1'b0) begin fails++; $display("FAIL busy_ignore got %b exp 0", ls_gnt); end
        tick; tick; tick;
        tests++; if ({if_rvalid, ls_gnt} !== 2'b11) begin fails++; $display("FAIL back_to_back1 got %b exp 11", {if_rvalid, ls_gnt}); end
        tick; ls_req = 0;
        tick; tick; tick;
        if_req = 1; ls_req = 1;
        #1;
        tests++; if ({ls_done, ls_rdata} !== {1'b1, 32'hDEAABEEF}) begin fails++; $display("FAIL arb_ls_read got %b %h exp 1 deaabeef", ls_done, ls_rdata); end
        tests++; if ({if_gnt, ls_gnt} !== 2'b10) begin fails++; $display("FAIL tie2 got %b exp 10", {if_gnt, ls_gnt}); end
        tick; if_req = 0; ls_req = 0;
        tick; tick; tick; tick;
    endtask

    task automatic test_reset_mid_write;
        mem[8'h20] = 16'h1111; mem[8'h21] = 16'h2222;
        ls_req = 1; ls_we = 1; ls_addr = 7'h10; ls_wdata = 32'hAAAA5555; ls_be = 4'hF;
        #1;
        tick; ls_req = 0;
        tick; reset = 1;
        #1;
        tests++; if ({ram_we, ram_re} !== 2'b00) begin fails++; $display("FAIL rst_we_forced got %b exp 00", {ram_we, ram_re}); end
        tick; reset = 0;
        tests++; if (ls_done !== 1'b0) begin fails++; $display("FAIL rst_no_done got %b exp 0", ls_done); end
        tests++; if ({mem[8'h20], mem[8'h21]} !== 32'h55552222) begin fails++; $display("FAIL rst_mem got %h %h exp 5555 2222", mem[8'h20], mem[8'h21]); end
        tests++; if ({ram_we, ram_waddr, ram_mask} !== {1'b0, 8'h00, 16'hFFFF}) begin fails++; $display("FAIL rst_pins got %b %h %h exp 0 00 ffff", ram_we, ram_waddr, ram_mask); end
        if_req = 1;
        #1;
        tests++; if (if_gnt !== 1'b1) begin fails++; $display("FAIL rst_idle_gnt got %b exp 1", if_gnt); end
        if_req = 0;
        tick;
        tests++; if ({ram_re, ram_we} !== 2'b00) begin fails++; $display("FAIL dropped_req got %b exp 00", {ram_re, ram_we}); end
    endtask

    task automatic test_dropped_req;
        if_req = 1; if_addr = 7'h10;
        #1;
        tick; if_req = 0; ls_req = 1; ls_we = 0; ls_addr = 7'h10;
        #1;
        tests++; if (ls_gnt !== 1'b0) begin fails++; $display("FAIL drop_busy_gnt got %b exp 0", ls_gnt); end
        tick; ls_req = 0;
        tick; tick;
        tests++; if ({if_rvalid, if_rdata, ls_gnt} !== {1'b1, 32'h22225555, 1'b0}) begin fails++; $display("FAIL drop_fetch got %b %h %b exp 1 22225555 0", if_rvalid, if_rdata, ls_gnt); end
        tick;
        tests++; if ({ls_gnt, ls_done, ram_re, ram_we, ram_raddr, ram_mask} !== {4'b0000, 8'h00, 16'hFFFF}) begin fails++; $display("FAIL drop_idle got %b%b%b%b %h %h exp idle", ls_gnt, ls_done, ram_re, ram_we, ram_raddr, ram_mask); end
        tick; tick; tick; tick;
        tests++; if (ls_done !== 1'b0) begin fails++; $display("FAIL drop_no_done got %b exp 0", ls_done); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0;
        test_reset;
        test_write;
        test_fetch;
        test_byte_write;
        test_arbitration;
        test_reset_mid_write;
        test_dropped_req;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares one 256x16 iCE40 block RAM between the instruction-fetch port (read-only) and the load/store port (read/write with byte enables).
- Each access is a 32-bit word split into two 16-bit RAM cycles: low half at RAM address {addr,0}, high half at {addr,1}.
- Drives the RAM wrapper's read and write address, data, enable and mask pins. RCLKE/WCLKE are tied high outside this block, and RCLK/WCLK connect to clk.

Parameters:
- WADDR_W, 7, word-address width; RAM address width = WADDR_W+1.
- RAM_DW, 16, RAM data width; port data width = 2*RAM_DW.

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- if_req  in  1  fetch request, level, held until if_gnt
- if_addr  in  7  fetch word address, sampled on the if_gnt cycle
- if_gnt  out  1  fetch request accepted, one-cycle pulse
- if_rvalid  out  1  fetch data valid, one-cycle pulse
- if_rdata  out  32  fetch data, held until the next fetch read completes
- ls_req  in  1  load/store request, level, held until ls_gnt
- ls_we  in  1  1=write, 0=read, sampled on the ls_gnt cycle
- ls_addr  in  7  word address
- ls_wdata  in  32  write data
- ls_be  in  4  byte enables, bit i covers byte i
- ls_gnt  out  1  load/store request accepted, one-cycle pulse
- ls_done  out  1  access complete (read or write), one-cycle pulse
- ls_rdata  out  32  read data, valid with ls_done when the access was a read
- ram_raddr  out  8  RAM read address
- ram_re  out  1  RAM read enable
- ram_rdata  in  16  RAM read data (registered, 1-cycle latency)
- ram_waddr  out  8  RAM write address
- ram_wdata  out  16  RAM write data
- ram_mask  out  16  RAM write mask, 1 = bit NOT written
- ram_we  out  1  RAM write enable

Behaviour:
- Reset values: state IDLE; all gnt, rvalid and done outputs 0; if_rdata/ls_rdata 0; RR pointer 0 (fetch wins the first tie).
- RAM pins at reset and whenever idle: ram_re=ram_we=0, addresses 0, ram_wdata 0, ram_mask 16'hFFFF.
- ram_re and ram_we are combinationally forced to 0 while reset is high.
- FSM states: IDLE, RD0, RD1, RD2, WR0, WR1.
- IDLE arbitration, combinational grant:
  - Only one req high: grant that requester.
  - Both high: grant the requester not granted last. Pointer updates on every grant.
  - On grant, capture addr, we, wdata and be. Fetch always reads.
  - Next state: RD0 for a read, WR0 for a write.
- Read timing, grant at cycle T:
  - RD0 (T+1): ram_re=1, raddr={addr,0}.
  - RD1 (T+2): ram_re=1, raddr={addr,1}; capture ram_rdata as the low half.
  - RD2 (T+3): capture ram_rdata as the high half.
  - T+4: rdata register updated, rvalid/done pulse, state IDLE. A new grant is allowed in this same cycle.
  - Read throughput: 4 cycles per access.
- Write timing, grant at cycle T:
  - WR0 (T+1): waddr={addr,0}, wdata=wdata[15:0], mask=~{{8{be[1]}},{8{be[0]}}}.
  - WR1 (T+2): waddr={addr,1}, wdata=wdata[31:16], mask=~{{8{be[3]}},{8{be[2]}}}.
  - ram_we=1 in each phase only if that half has at least one enabled byte. Timing is unchanged when a half is skipped.
  - T+3: ls_done pulse, state IDLE, new grant allowed.
- Requests never time out. A req dropped before its grant has no effect.
- Request inputs are ignored outside IDLE.
- Reset mid-operation:
  - Returns to IDLE with no rvalid/done.
  - A half already written stays written (no rollback).
  - A half whose cycle coincides with reset is not written.
- The unserved requester keeps its req high and is granted at the next IDLE cycle. Starvation bound: 4 cycles of waiting per competing access.

Test Plan:
- Write, ls_addr=7'h05, wdata=32'hDEADBEEF, be=4'hF → RAM[0x0A]=16'hBEEF, RAM[0x0B]=16'hDEAD, ls_done at T+3.
- Fetch read at if_addr=7'h05 after that write → if_rvalid at T+4, if_rdata=32'hDEADBEEF; ram_raddr sequence 0x0A, 0x0B.
- Byte write, be=4'b0100, wdata=32'h00AA0000 → WR0 ram_we=0; WR1 ram_we=1, mask=16'hFF00. Readback gives 32'hDEAABEEF.
- Both req high after reset → fetch granted first, then ls on the if_rvalid cycle. Both high again → fetch granted (last was ls). No idle gap between accesses.
- Reset asserted during WR1 of a write to addr 7'h10 → RAM[0x20] written, RAM[0x21] unchanged, no ls_done, state IDLE next cycle.
- ls read with ls_req dropped before any grant while fetch is busy → no ls_gnt, no ls_done, RAM pins idle after the fetch completes.
